// File: rtl/bus_pkg.sv
// Shared types and widths for the CPU-side bus cycle sequencer.
// Imported by bus_cycle_sequencer; also visible to the parent beside Bus_Conductor.
package bus_pkg;

  localparam int BUS_W = 8;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    ACK
  } bus_state_t;

endpackage

// File: rtl/bus_cycle_sequencer.sv
// Sequences single CPU reads/writes as ALE address phase, timed data phase, ack.
// BUS_READY_EN adds a ready input that stretches the data phase once the wait count expires.
module bus_cycle_sequencer
  import bus_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             we,
  input  logic [BUS_W-1:0] addr,
  input  logic [BUS_W-1:0] wdata,
  output logic             ack,
  output logic [BUS_W-1:0] rdata,
  output logic             busy,
  output logic             ALE,
  output logic             adbd,
  output logic [BUS_W-1:0] addr_bus,
  output logic [BUS_W-1:0] Data_Bus_Out,
  input  logic [BUS_W-1:0] Data_Bus_In,
  output logic             rd_n,
`ifdef BUS_READY_EN
  output logic             wr_n,
  input  logic             ready
`else
  output logic             wr_n
`endif
);

  bus_state_t       state;
  logic             we_q;
  logic [CNT_W-1:0] cnt;
  logic             rdy;

`ifdef BUS_READY_EN
  assign rdy = ready;
`else
  assign rdy = 1'b1;
`endif

  // Outputs are registered alongside the state so they match its decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      we_q         <= 1'b0;
      cnt          <= '0;
      ALE          <= 1'b0;
      adbd         <= 1'b0;
      rd_n         <= 1'b1;
      wr_n         <= 1'b1;
      ack          <= 1'b0;
      busy         <= 1'b0;
      addr_bus     <= '0;
      Data_Bus_Out <= '0;
      rdata        <= '0;
    end else begin
      ALE  <= 1'b0;
      adbd <= 1'b0;
      rd_n <= 1'b1;
      wr_n <= 1'b1;
      ack  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            state        <= ADDR;
            addr_bus     <= addr;
            Data_Bus_Out <= wdata;
            we_q         <= we;
            cnt          <= CNT_W'(WAIT_CYCLES);
            ALE          <= 1'b1;
            busy         <= 1'b1;
          end
        end
        ADDR: begin
          state <= DATA;
          adbd  <= we_q;
          wr_n  <= ~we_q;
          rd_n  <= we_q;
        end
        DATA: begin
          if (cnt != '0) begin
            cnt  <= cnt - 1'b1;
            adbd <= we_q;
            wr_n <= ~we_q;
            rd_n <= we_q;
          end else if (rdy) begin
            state <= ACK;
            ack   <= 1'b1;
            if (!we_q) rdata <= Data_Bus_In;
          end else begin
            adbd <= we_q;
            wr_n <= ~we_q;
            rd_n <= we_q;
          end
        end
        ACK: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
